stopwatch_bcd: RTL and testbench
================================

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 SHALL have parameter: TICKS_PER_COUNT, default 4, number of slow-clock rising edges per one-second increment (4 Hz slow clock from divider).
REQ-002 SHALL have port: iclk  input  1  system clock, 50 MHz; single clock domain.
REQ-003 SHALL have port: irst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: islowclk  input  1  divided clock from divider stage; sampled as data, never used as a clock.
REQ-005 SHALL have port: istartstop  input  1  start/stop button level, pre-debounced, active-high.
REQ-006 SHALL have port: iclear  input  1  clear button level, pre-debounced, active-high.
REQ-007 SHALL have ports: osec0, osec1, omin0, omin1  output  4 each  BCD digits: seconds ones 0-9, seconds tens 0-5, minutes ones 0-9, minutes tens 0-5.
REQ-008 SHALL have ports: orunning  output  1  high in RUN; otick  output  1  one-iclk pulse per detected islowclk rising edge; owrap  output  1  one-iclk pulse on 59:59->00:00.

Function
REQ-009 islowclk, istartstop, iclear SHALL each pass a 2-flop synchronizer, then a history flop for rising-edge detection; each rising edge SHALL yield exactly one 1-cycle internal pulse.
REQ-010 otick SHALL assert for one cycle; registered digit updates from that tick SHALL appear at the 3rd iclk rising edge after islowclk rises (setup met).
REQ-011 FSM states: IDLE, RUN, PAUSE; IDLE--start->RUN; RUN--start->PAUSE; PAUSE--start->RUN; clear from any state->IDLE.
REQ-012 Clear pulse coincident with start pulse: clear wins; next state IDLE.
REQ-013 Entering IDLE SHALL zero all four digits and the prescaler in the same cycle.
REQ-014 Prescaler (width ceil(log2(TICKS_PER_COUNT))) SHALL count ticks only in RUN; hold in PAUSE; forced 0 in IDLE.
REQ-015 Prescaler reaching TICKS_PER_COUNT-1 with tick SHALL wrap to 0 and increment digits by one second.
REQ-016 Digit carry: osec0 9->0 carries to osec1; osec1 5->0 to omin0; omin0 9->0 to omin1; omin1 5->0 with all lower at max wraps to 00:00 and pulses owrap.
REQ-017 Ticks in IDLE or PAUSE SHALL not change digits; otick SHALL still pulse in every state.
REQ-018 Start pulse and tick in same cycle: state transition and tick evaluated against current state (RUN->PAUSE still counts that tick).
REQ-019 orunning SHALL be registered, equal to (state==RUN).

Reset
REQ-020 irst_n low SHALL immediately set: state IDLE; digits 0; prescaler 0; otick, owrap, orunning 0; islowclk sync/history flops 0.
REQ-021 Button sync and history flops SHALL reset to 1 so a button held through reset release produces no press.
REQ-022 Reset asserted mid-RUN SHALL discard count; after release block waits in IDLE.

Configuration
REQ-023 Macro STOPWATCH_LAP_EN defined: add port ilap (input, 1, pre-debounced) with same sync/edge logic; a lap press in RUN freezes displayed digits while internal count continues; next lap press resumes live display; clear or reset unfreezes; lap press in IDLE/PAUSE ignored.
REQ-024 Macro undefined: no ilap port, no freeze register; digit outputs always live.

Verification
REQ-025 Reset, start, 4 islowclk rising edges -> osec0=1 at 3rd iclk edge after 4th rise; otick pulsed 4 times.
REQ-026 Preload by running 3599 s -> display 59:59; 4 more ticks -> 00:00, owrap one cycle.
REQ-027 RUN, 2 ticks, start (PAUSE), 10 ticks, start, 2 ticks -> osec0=1; orunning 1/0/1.
REQ-028 Clear and start pulse same cycle while RUN at 00:07 -> IDLE, 00:00, orunning 0.
REQ-029 istartstop held high across irst_n release -> stays IDLE; release/repress -> RUN.
REQ-030 STOPWATCH_LAP_EN: RUN at 00:03, lap, 8 ticks -> display 00:03; lap -> display 00:05.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// MM:SS stopwatch with BCD digits. Slow clock and buttons are sampled as data in the iclk domain.
// Optional lap/freeze display is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd #(
    parameter int TICKS_PER_COUNT = 4
) (
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       islowclk,
    input  logic       istartstop,
    input  logic       iclear,
`ifdef STOPWATCH_LAP_EN
    input  logic       ilap,
`endif
    output logic [3:0] osec0,
    output logic [3:0] osec1,
    output logic [3:0] omin0,
    output logic [3:0] omin1,
    output logic       orunning,
    output logic       otick,
    output logic       owrap
);

    localparam int PW = (TICKS_PER_COUNT > 1) ? $clog2(TICKS_PER_COUNT) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] min1;
        logic [3:0] min0;
        logic [3:0] sec1;
        logic [3:0] sec0;
    } digits_t;

    // Each pipe is {history, sync2, sync1}; a rise is sync2 high while history still low.
    logic [2:0] slow_pipe_q, slow_pipe_d;
    logic [2:0] ss_pipe_q, ss_pipe_d;
    logic [2:0] clr_pipe_q, clr_pipe_d;
    logic       tick_pulse, ss_pulse, clr_pulse;

    state_e      state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    digits_t     digits_q, digits_d;
    digits_t     display;
    logic        otick_q, otick_d;
    logic        owrap_q, owrap_d;
    logic        orunning_q, orunning_d;

    always_comb begin
        slow_pipe_d = {slow_pipe_q[1:0], islowclk};
        ss_pipe_d   = {ss_pipe_q[1:0], istartstop};
        clr_pipe_d  = {clr_pipe_q[1:0], iclear};
    end

    assign tick_pulse = slow_pipe_q[1] & ~slow_pipe_q[2];
    assign ss_pulse   = ss_pipe_q[1] & ~ss_pipe_q[2];
    assign clr_pulse  = clr_pipe_q[1] & ~clr_pipe_q[2];

    // NOTE: button pipes reset to all-ones so a button held through reset release is not seen as a press.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            slow_pipe_q <= 3'b000;
            ss_pipe_q   <= 3'b111;
            clr_pipe_q  <= 3'b111;
        end else begin
            slow_pipe_q <= slow_pipe_d;
            ss_pipe_q   <= ss_pipe_d;
            clr_pipe_q  <= clr_pipe_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        digits_d = digits_q;
        owrap_d  = 1'b0;

        if (clr_pulse) begin
            state_d = IDLE;
        end else if (ss_pulse) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end

        // Counting is judged against the current state, so a stop press still counts its tick.
        if (!clr_pulse && (state_q == RUN) && tick_pulse) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (digits_q.sec0 == 4'd9) begin
                    digits_d.sec0 = 4'd0;
                    if (digits_q.sec1 == 4'd5) begin
                        digits_d.sec1 = 4'd0;
                        if (digits_q.min0 == 4'd9) begin
                            digits_d.min0 = 4'd0;
                            if (digits_q.min1 == 4'd5) begin
                                digits_d.min1 = 4'd0;
                                owrap_d       = 1'b1;
                            end else begin
                                digits_d.min1 = digits_q.min1 + 4'd1;
                            end
                        end else begin
                            digits_d.min0 = digits_q.min0 + 4'd1;
                        end
                    end else begin
                        digits_d.sec1 = digits_q.sec1 + 4'd1;
                    end
                end else begin
                    digits_d.sec0 = digits_q.sec0 + 4'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (state_d == IDLE) begin
            digits_d = '0;
            presc_d  = '0;
        end

        otick_d    = tick_pulse;
        orunning_d = (state_d == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            digits_q   <= '0;
            otick_q    <= 1'b0;
            owrap_q    <= 1'b0;
            orunning_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            digits_q   <= digits_d;
            otick_q    <= otick_d;
            owrap_q    <= owrap_d;
            orunning_q <= orunning_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [2:0] lap_pipe_q, lap_pipe_d;
    logic       lap_pulse;
    logic       frozen_q, frozen_d;
    digits_t    lap_digits_q, lap_digits_d;

    assign lap_pipe_d = {lap_pipe_q[1:0], ilap};
    assign lap_pulse  = lap_pipe_q[1] & ~lap_pipe_q[2];

    // A lap press in RUN toggles the freeze; entering IDLE always releases it.
    always_comb begin
        frozen_d     = frozen_q;
        lap_digits_d = lap_digits_q;
        if (state_d == IDLE) begin
            frozen_d = 1'b0;
        end else if ((state_q == RUN) && lap_pulse) begin
            frozen_d = ~frozen_q;
            if (!frozen_q) begin
                lap_digits_d = digits_q;
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            lap_pipe_q   <= 3'b111;
            frozen_q     <= 1'b0;
            lap_digits_q <= '0;
        end else begin
            lap_pipe_q   <= lap_pipe_d;
            frozen_q     <= frozen_d;
            lap_digits_q <= lap_digits_d;
        end
    end

    assign display = frozen_q ? lap_digits_q : digits_q;
`else
    assign display = digits_q;
`endif

    assign osec0    = display.sec0;
    assign osec1    = display.sec1;
    assign omin0    = display.min0;
    assign omin1    = display.min1;
    assign otick    = otick_q;
    assign owrap    = owrap_q;
    assign orunning = orunning_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: seconds-count reference model checked every cycle, plus directed literal checks.
// Lap scenarios are exercised when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_bcd;

    localparam int TPC = 4;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       iclk = 1'b0;
    logic       irst_n = 1'b0;
    logic       islowclk = 1'b0;
    logic       istartstop = 1'b0;
    logic       iclear = 1'b0;
    logic       ilap = 1'b0;
    logic [3:0] osec0, osec1, omin0, omin1;
    logic       orunning, otick, owrap;

    always #5 iclk = ~iclk;

    stopwatch_bcd #(.TICKS_PER_COUNT(TPC)) dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .islowclk   (islowclk),
        .istartstop (istartstop),
        .iclear     (iclear),
`ifdef STOPWATCH_LAP_EN
        .ilap       (ilap),
`endif
        .osec0      (osec0),
        .osec1      (osec1),
        .omin0      (omin0),
        .omin1      (omin1),
        .orunning   (orunning),
        .otick      (otick),
        .owrap      (owrap)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: elapsed seconds as an integer, state as 0=idle 1=run 2=pause.
    // An input rise takes effect at the third iclk edge after it is first sampled high.
    int       m_state, m_secs, m_presc, m_lap_secs;
    bit       m_frozen, m_tick, m_wrap;
    logic [2:0] h_slow, h_ss, h_clr, h_lap;

    always @(posedge iclk or negedge irst_n) begin : model
        int st, secs, presc, lap_secs;
        bit frozen, wrap, ev_tick, ev_ss, ev_clr, ev_lap;
        if (!irst_n) begin
            m_state <= 0; m_secs <= 0; m_presc <= 0; m_lap_secs <= 0;
            m_frozen <= 1'b0; m_tick <= 1'b0; m_wrap <= 1'b0;
            h_slow <= 3'b000; h_ss <= 3'b111; h_clr <= 3'b111; h_lap <= 3'b111;
        end else begin
            ev_tick = h_slow[1] && !h_slow[2];
            ev_ss   = h_ss[1] && !h_ss[2];
            ev_clr  = h_clr[1] && !h_clr[2];
            ev_lap  = LAP_EN && h_lap[1] && !h_lap[2];
            st = m_state; secs = m_secs; presc = m_presc;
            lap_secs = m_lap_secs; frozen = m_frozen; wrap = 1'b0;
            if (ev_clr) begin
                st = 0; secs = 0; presc = 0; frozen = 1'b0;
            end else begin
                if (m_state == 1 && ev_lap) begin
                    if (!frozen) lap_secs = secs;
                    frozen = !frozen;
                end
                if (m_state == 1 && ev_tick) begin
                    presc = presc + 1;
                    if (presc == TPC) begin
                        presc = 0;
                        secs = secs + 1;
                        if (secs == 3600) begin
                            secs = 0;
                            wrap = 1'b1;
                        end
                    end
                end
                if (ev_ss) st = (m_state == 1) ? 2 : 1;
            end
            m_state <= st; m_secs <= secs; m_presc <= presc;
            m_lap_secs <= lap_secs; m_frozen <= frozen;
            m_tick <= ev_tick; m_wrap <= wrap;
            h_slow <= {h_slow[1:0], islowclk};
            h_ss   <= {h_ss[1:0], istartstop};
            h_clr  <= {h_clr[1:0], iclear};
            h_lap  <= {h_lap[1:0], ilap};
        end
    end

    always @(negedge iclk) begin : compare
        int disp;
        if (irst_n) begin
            disp = m_frozen ? m_lap_secs : m_secs;
            check("osec0", int'(osec0), disp % 10);
            check("osec1", int'(osec1), (disp / 10) % 6);
            check("omin0", int'(omin0), (disp / 60) % 10);
            check("omin1", int'(omin1), disp / 600);
            check("otick", int'(otick), int'(m_tick));
            check("owrap", int'(owrap), int'(m_wrap));
            check("orunning", int'(orunning), (m_state == 1) ? 1 : 0);
        end
    end

    int tick_count = 0;
    int wrap_count = 0;
    always @(posedge iclk) begin
        if (otick) tick_count <= tick_count + 1;
        if (owrap) wrap_count <= wrap_count + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge iclk);
    endtask

    task automatic tick();
        islowclk = 1'b1; cycles(1);
        islowclk = 1'b0; cycles(1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_ss();
        istartstop = 1'b1; cycles(2);
        istartstop = 1'b0; cycles(2);
    endtask

    task automatic press_clr();
        iclear = 1'b1; cycles(2);
        iclear = 1'b0; cycles(2);
    endtask

    task automatic press_lap();
        ilap = 1'b1; cycles(2);
        ilap = 1'b0; cycles(2);
    endtask

    task automatic check_time(input string name, input int mm, input int ss);
        check({name, "_min1"}, int'(omin1), mm / 10);
        check({name, "_min0"}, int'(omin0), mm % 10);
        check({name, "_sec1"}, int'(osec1), ss / 10);
        check({name, "_sec0"}, int'(osec0), ss % 10);
    endtask

    initial begin
        int base;
        int r;
        @(negedge iclk);
        irst_n = 1'b0;
        cycles(3);
        check_time("reset", 0, 0);
        check("reset_otick", int'(otick), 0);
        check("reset_owrap", int'(owrap), 0);
        check("reset_orunning", int'(orunning), 0);
        irst_n = 1'b1;
        cycles(2);

        // One second after four slow-clock rises; digit lands on the third edge after the fourth rise.
        press_ss();
        check("start_running", int'(orunning), 1);
        base = tick_count;
        ticks(3);
        islowclk = 1'b1;
        @(posedge iclk); @(posedge iclk); #1;
        check("first_sec_edge2", int'(osec0), 0);
        @(posedge iclk); #1;
        check("first_sec_edge3", int'(osec0), 1);
        @(negedge iclk);
        islowclk = 1'b0;
        cycles(3);
        check("tick_pulses", tick_count - base, 4);

        // Clear and start together at 00:07.
        ticks(6 * TPC);
        cycles(2);
        check_time("at_7s", 0, 7);
        iclear = 1'b1; istartstop = 1'b1; cycles(2);
        iclear = 1'b0; istartstop = 1'b0; cycles(3);
        check_time("clr_and_start", 0, 0);
        check("clr_and_start_run", int'(orunning), 0);

        // Run, pause, run.
        press_ss();
        ticks(2);
        check("pause_seq_run", int'(orunning), 1);
        press_ss();
        check("pause_seq_pause", int'(orunning), 0);
        ticks(10);
        press_ss();
        check("pause_seq_rerun", int'(orunning), 1);
        ticks(2);
        cycles(2);
        check("pause_seq_sec0", int'(osec0), 1);

        // Reset mid-run discards the count and the block waits in IDLE.
        ticks(3 * TPC);
        irst_n = 1'b0; cycles(2);
        irst_n = 1'b1; cycles(2);
        ticks(2 * TPC);
        cycles(2);
        check_time("after_mid_reset", 0, 0);
        check("after_mid_reset_run", int'(orunning), 0);

        // Start held through reset release produces no press.
        istartstop = 1'b1;
        irst_n = 1'b0; cycles(2);
        irst_n = 1'b1; cycles(6);
        check("held_start_idle", int'(orunning), 0);
        istartstop = 1'b0; cycles(3);
        press_ss();
        check("repress_run", int'(orunning), 1);

        // Full-range run to 59:59, then the wrap.
        press_clr();
        press_ss();
        ticks(3599 * TPC);
        cycles(2);
        check_time("preload", 59, 59);
        base = wrap_count;
        ticks(TPC);
        cycles(3);
        check_time("wrapped", 0, 0);
        check("wrap_pulses", wrap_count - base, 1);

`ifdef STOPWATCH_LAP_EN
        press_clr();
        press_ss();
        ticks(3 * TPC);
        cycles(2);
        press_lap();
        ticks(2 * TPC);
        cycles(2);
        check_time("lap_frozen", 0, 3);
        press_lap();
        check_time("lap_live", 0, 5);
`endif

        // Randomized traffic against the model.
        press_clr();
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 66) begin
                tick();
            end else if (r < 78) begin
                press_ss();
            end else if (r < 82) begin
                press_clr();
            end else if (r < 90) begin
                press_lap();
            end else if (r < 94) begin
                islowclk = 1'b1; istartstop = 1'b1; cycles(2);
                islowclk = 1'b0; istartstop = 1'b0; cycles(2);
            end else if (r < 96) begin
                iclear = 1'b1; istartstop = 1'b1; islowclk = 1'b1; cycles(2);
                iclear = 1'b0; istartstop = 1'b0; islowclk = 1'b0; cycles(2);
            end else if (r < 99) begin
                cycles(int'($urandom_range(1, 5)));
            end else begin
                irst_n = 1'b0; cycles(1);
                irst_n = 1'b1; cycles(1);
            end
        end
        cycles(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
